// File: rtl/t03_sprite_pkg.sv
// rtl/t03_sprite_pkg.sv - shared player-sprite geometry, widths and writer state type
package t03_sprite_pkg;

    localparam int X_LENGTH    = 15;
    localparam int Y_LENGTH    = 20;
    localparam int PIX_W       = 8;
    localparam int NPIX        = X_LENGTH * Y_LENGTH;
    localparam int SPRITE_BITS = NPIX * PIX_W;
    localparam int CNT_W       = 9;
    localparam int IDX_W       = 12;

    localparam logic [PIX_W-1:0] TRANSPARENT = '0;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PEND
    } state_t;

endpackage

// File: rtl/t03_player_sprite_writer_if.sv
// rtl/t03_player_sprite_writer_if.sv - pixel stream handshake into the sprite writer
interface t03_player_sprite_writer_if;
    import t03_sprite_pkg::*;

    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);

endinterface

// File: rtl/t03_sprite_addr_gen.sv
// rtl/t03_sprite_addr_gen.sv - pixel counters and byte slot index for the back buffer
// Mirroring is compiled in with T03_SPRITE_FLIP_EN.
module t03_sprite_addr_gen
    import t03_sprite_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic beat_i,
`ifdef T03_SPRITE_FLIP_EN
    input  logic flip_i,
`endif
    output cnt_t slot_o,
    output logic last_o
);

    cnt_t k_q, k_d;
    cnt_t pix_idx;

    assign last_o = (k_q == cnt_t'(NPIX - 1));

`ifdef T03_SPRITE_FLIP_EN
    logic [3:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic       flip_q, flip_d;

    always_comb begin
        k_d    = k_q;
        col_d  = col_q;
        row_d  = row_q;
        flip_d = flip_q;
        if (clear_i) begin
            k_d    = '0;
            col_d  = '0;
            row_d  = '0;
            flip_d = flip_i;
        end else if (beat_i && !last_o) begin
            k_d = k_q + cnt_t'(1);
            if (col_q == 4'(X_LENGTH - 1)) begin
                col_d = '0;
                row_d = row_q + 5'd1;
            end else begin
                col_d = col_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q    <= '0;
            col_q  <= '0;
            row_q  <= '0;
            flip_q <= 1'b0;
        end else begin
            k_q    <= k_d;
            col_q  <= col_d;
            row_q  <= row_d;
            flip_q <= flip_d;
        end
    end

    // Display position of the incoming pixel; mirrored column when flipping.
    assign pix_idx = cnt_t'(row_q) * cnt_t'(X_LENGTH)
                   + (flip_q ? cnt_t'(4'(X_LENGTH - 1) - col_q) : cnt_t'(col_q));
`else
    always_comb begin
        k_d = k_q;
        if (clear_i) begin
            k_d = '0;
        end else if (beat_i && !last_o) begin
            k_d = k_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    assign pix_idx = k_q;
`endif

    // Pixel 0 lands in the top byte of the packed bus.
    assign slot_o = cnt_t'(NPIX - 1) - pix_idx;

endmodule

// File: rtl/t03_player_sprite_writer.sv
// rtl/t03_player_sprite_writer.sv - double-buffered player sprite writer, swap on frame_start
// Optional horizontal mirroring: T03_SPRITE_FLIP_EN.
module t03_player_sprite_writer
    import t03_sprite_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    t03_player_sprite_writer_if.slave  pix_if,
    input  logic                       start,
    input  logic                       frame_start,
    input  logic                       flip_x,
    output logic [SPRITE_BITS-1:0]     player,
    output logic                       busy,
    output logic                       load_done
);

    state_t                 state_q, state_d;
    logic                   load_done_q, load_done_d;
    logic [SPRITE_BITS-1:0] back_q;
    logic [SPRITE_BITS-1:0] player_q;

    logic clear, beat, swap, last;
    cnt_t slot;
    idx_t bit_lsb;

    t03_sprite_addr_gen u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .beat_i  (beat),
`ifdef T03_SPRITE_FLIP_EN
        .flip_i  (flip_x),
`endif
        .slot_o  (slot),
        .last_o  (last)
    );

    assign bit_lsb = idx_t'(slot) << 3;

    always_comb begin
        state_d     = state_q;
        load_done_d = 1'b0;
        clear       = 1'b0;
        beat        = 1'b0;
        swap        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // A restart wins over a same-cycle pixel, which is dropped.
                if (start) begin
                    clear = 1'b1;
                end else if (pix_if.pix_valid) begin
                    beat = 1'b1;
                    if (last) begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (frame_start) begin
                    swap        = 1'b1;
                    load_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            load_done_q <= 1'b0;
            back_q      <= '0;
            player_q    <= '0;
        end else begin
            state_q     <= state_d;
            load_done_q <= load_done_d;
            if (beat) begin
                back_q[bit_lsb +: PIX_W] <= pix_if.pix_data;
            end
            if (swap) begin
                player_q <= back_q;
            end
        end
    end

    assign pix_if.pix_ready = (state_q == LOAD);
    assign busy             = (state_q != IDLE);
    assign load_done        = load_done_q;
    assign player           = player_q;

endmodule
